packet_data_reader: RTL and testbench
=====================================

PACKET_DATA_READER -- requirements
Module: packet_data_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning packet RAM address width (1024 entries).
REQ-002 SHALL have parameter DATA_W, default 8, meaning packet RAM byte width.
REQ-003 SHALL have port Clock  input  1  single clock for all logic, which is also the RAM read clock.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request, accepted only while busy=0.
REQ-006 SHALL have port start_addr  input  ADDR_W  first RAM address of the packet.
REQ-007 SHALL have port length  input  ADDR_W+1  byte count; valid range 0..1024.
REQ-008 SHALL have port busy  output  1  high from start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last byte handshake.
REQ-010 SHALL have port RdAddress  output  ADDR_W  RAM read address.
REQ-011 SHALL have port RdClockEn  output  1  RAM read enable; RAM Q is valid in the cycle after the edge that samples RdAddress.
REQ-012 SHALL have port Q  input  DATA_W  RAM read data.
REQ-013 SHALL have port tx_data  output  DATA_W  streamed byte.
REQ-014 SHALL have port tx_valid  output  1  tx_data valid.
REQ-015 SHALL have port tx_ready  input  1  downstream accept.
REQ-016 SHALL have port tx_last  output  1  qualifies the final byte, meaningful only while tx_valid=1.

Function
REQ-017 SHALL implement states IDLE, READ and DRAIN.
- IDLE->READ on start with length>=1.
- READ->DRAIN once all reads are issued.
- DRAIN->IDLE on the handshake of the last byte.
REQ-018 SHALL latch start_addr and length on the accepting edge, ignore start while busy=1, and clamp length>1024 to 1024.
REQ-019 SHALL treat start with length=0 as no RAM access and no tx_valid, with done pulsed in the following cycle and busy remaining 0.
REQ-020 SHALL increment the read address by 1 per issued read, wrapping modulo 2^ADDR_W (0x3FF->0x000).
REQ-021 SHALL buffer bytes in a 2-entry output buffer and assert RdClockEn only when the buffered count plus the in-flight read count is below 2, so that no byte is lost or duplicated under backpressure.
REQ-022 SHALL capture Q into the buffer in the cycle after the edge that sampled the address.
REQ-023 SHALL meet this latency: with start sampled at edge 0, the first RdClockEn is high in cycle 1 and the first tx_valid is high in cycle 3.
REQ-024 SHALL sustain 1 byte/cycle while tx_ready stays 1.
REQ-025 SHALL hold tx_data, tx_last and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-026 SHALL assert tx_last exactly on byte number length.
REQ-027 SHALL pulse done for one cycle after the last handshake edge and drop busy in that same cycle; start may be accepted in that cycle.
REQ-028 SHALL never assert RdClockEn in IDLE.

Reset
REQ-029 SHALL, on Reset=1, asynchronously force state=IDLE, busy=0, done=0, RdClockEn=0, RdAddress=0, tx_valid=0, tx_last=0 and tx_data=0, and clear the buffer and in-flight count.
REQ-030 SHALL discard an operation interrupted by Reset, emitting no further bytes and no done pulse.

Structure
REQ-031 SHALL place ADDR_W, DATA_W, MAX_LEN=1024 and the state enum in shared package packet_rd_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module pkt_rd_skid (valid/ready in and out, parameter DATA_W).

Verification
REQ-033 SHALL cover: RAM preloaded 0x00..0x0F at addr 0x000, start_addr=0x000, length=16, tx_ready=1 -> bytes 0x00..0x0F on consecutive cycles, first tx_valid at cycle 3, tx_last on 0x0F, one done pulse.
REQ-034 SHALL cover: start_addr=0x3FE, length=4 -> RdAddress sequence 0x3FE, 0x3FF, 0x000, 0x001 and bytes in that order.
REQ-035 SHALL cover: length=8 with tx_ready toggling randomly at 50% -> exactly 8 handshakes in order, no RdClockEn while the buffer is full, tx_data stable while stalled.
REQ-036 SHALL cover: length=0 -> no RdClockEn, no tx_valid, done one cycle after start; and a start while busy=1 -> ignored, the first packet completes unchanged.
REQ-037 SHALL cover: Reset asserted after 3 bytes of a 10-byte packet -> all outputs 0 immediately, no done, and a new start after reset works normally.
REQ-038 SHALL cover: length=1024 -> 1024 bytes with tx_last only on the last one, followed by back-to-back start in the done cycle being accepted.

Source files
------------

// File: rtl/packet_rd_pkg.sv
// Shared definitions for the packet data reader.
// Holds the default RAM geometry, the largest packet the reader will
// stream, and the controller state type.
package packet_rd_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rdState_t;

endpackage

// File: rtl/pkt_rd_skid.sv
// Two-entry output buffer between the RAM read pipeline and the
// downstream byte stream.
//
// Ports:
//   clock, reset     - clock and asynchronous active-high reset
//   inValid/inReady  - write side; an entry is taken when both are high
//   inData           - entry being written
//   outValid/outReady- read side; the head leaves when both are high
//   outData          - head entry, held steady until it is taken
//   count            - number of entries currently held (0..2)
module pkt_rd_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [1:0]        count
);
  import packet_rd_pkg::*;

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic [1:0]        fill;
  logic              push;
  logic              pop;

  // slot0 is always the head, so the output is a plain register and
  // stays put while the consumer stalls. A write is accepted when full
  // only if the head leaves on the same edge.
  assign outValid = (fill != 2'd0);
  assign outData  = slot0;
  assign pop      = outValid & outReady;
  assign inReady  = (fill != 2'd2) | pop;
  assign push     = inValid & inReady;
  assign count    = fill;

  // Entry storage and fill level. When the head leaves with two entries
  // held, slot1 moves forward and a simultaneous write refills slot1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      fill  <= 2'd0;
    end else begin
      case (fill)
        2'd0: begin
          if (push) begin
            slot0 <= inData;
            fill  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= inData;
          end else if (push) begin
            slot1 <= inData;
            fill  <= 2'd2;
          end else if (pop) begin
            fill  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0 <= slot1;
            if (push) begin
              slot1 <= inData;
            end else begin
              fill  <= 2'd1;
            end
          end
        end
        default: fill <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/packet_data_reader.sv
// Streams a packet out of a synchronous-read packet RAM as a valid/ready
// byte stream. A start request latches the first address and the byte
// count; reads are issued one per cycle as long as the output buffer can
// absorb the returning data, so backpressure never drops or repeats bytes.
//
// Ports:
//   Clock, Reset       - single clock (also the RAM read clock), async reset
//   start              - one-cycle request, taken only while not busy
//   start_addr, length - first RAM address and byte count (clamped to 1024)
//   busy, done         - packet in progress / one-cycle completion pulse
//   RdAddress, RdClockEn - RAM read port; Q is valid the cycle after
//   Q                  - RAM read data
//   tx_data, tx_valid, tx_ready, tx_last - outgoing byte stream
module packet_data_reader #(
  parameter int ADDR_W = packet_rd_pkg::ADDR_W,
  parameter int DATA_W = packet_rd_pkg::DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] RdAddress,
  output logic              RdClockEn,
  input  logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last
);
  import packet_rd_pkg::*;

  localparam logic [ADDR_W:0] LenLimit = (ADDR_W+1)'(MAX_LEN);

  rdState_t          state;
  rdState_t          nextState;
  logic [ADDR_W-1:0] readAddr;
  logic [ADDR_W:0]   readsLeft;
  logic              inFlight;
  logic              inFlightLast;
  logic              doneReg;
  logic [ADDR_W:0]   startLen;
  logic              acceptStart;
  logic              lastRead;
  logic              lastHandshake;
  logic [2:0]        occupancy;
  logic              roomForRead;
  logic [1:0]        bufCount;
  logic              bufInReady;
  logic              bufOutValid;
  logic [DATA_W:0]   bufOut;

  assign startLen      = (length > LenLimit) ? LenLimit : length;
  assign acceptStart   = (state == IDLE) && start;
  assign lastRead      = (readsLeft == (ADDR_W+1)'(1));
  assign lastHandshake = tx_valid && tx_ready && tx_last;

  // Bytes that will still be held after this edge: what the buffer holds,
  // plus the read returning now, minus the byte leaving now. A new read
  // only lands one cycle later, so it is safe while this stays below 2,
  // and counting the departing byte is what allows one byte per cycle.
  assign occupancy   = {1'b0, bufCount} + {2'b00, inFlight}
                     - {2'b00, (tx_valid && tx_ready)};
  assign roomForRead = (occupancy < 3'd2);

  assign RdAddress = readAddr;
  assign done      = doneReg;

  // Controller state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A zero-length request never leaves IDLE; READ hands
  // over to DRAIN on the edge that issues the final read.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && (startLen != '0)) nextState = READ;
      READ:    if (RdClockEn && lastRead) nextState = DRAIN;
      DRAIN:   if (lastHandshake) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State outputs. Reads are issued only in READ, and only when the buffer
  // is guaranteed to have space for the returning byte.
  always_comb begin
    busy      = 1'b0;
    RdClockEn = 1'b0;
    case (state)
      IDLE: ;
      READ: begin
        busy      = 1'b1;
        RdClockEn = (readsLeft != '0) && roomForRead && bufInReady;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Read address/count bookkeeping, the in-flight read marker (carrying
  // whether it is the packet's final byte), and the done pulse. Done
  // follows either a zero-length request or the final byte's handshake.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      readAddr     <= '0;
      readsLeft    <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      inFlight     <= RdClockEn;
      inFlightLast <= RdClockEn && lastRead;
      doneReg      <= (acceptStart && (startLen == '0))
                   || ((state == DRAIN) && lastHandshake);
      if (acceptStart && (startLen != '0)) begin
        readAddr  <= start_addr;
        readsLeft <= startLen;
      end else if (RdClockEn) begin
        readAddr  <= readAddr + ADDR_W'(1);
        readsLeft <= readsLeft - (ADDR_W+1)'(1);
      end
    end
  end

  // The last-byte flag travels through the buffer alongside its data so it
  // stays aligned with tx_data under any stall pattern.
  pkt_rd_skid #(
    .DATA_W (DATA_W + 1)
  ) skid (
    .clock    (Clock),
    .reset    (Reset),
    .inValid  (inFlight),
    .inReady  (bufInReady),
    .inData   ({inFlightLast, Q}),
    .outValid (bufOutValid),
    .outReady (tx_ready),
    .outData  (bufOut),
    .count    (bufCount)
  );

  assign tx_valid = bufOutValid;
  assign tx_data  = bufOut[DATA_W-1:0];
  assign tx_last  = bufOutValid && bufOut[DATA_W];

endmodule

// File: tb/tb_packet_data_reader.sv
// Self-checking bench for packet_data_reader. A RAM model answers reads,
// a monitor records handshakes, reads and done pulses, and each scenario
// task compares the recording against bytes computed from RAM contents.
module tb_packet_data_reader;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int RAMSZ = 1024;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] RdAddress;
  logic          RdClockEn;
  logic [DW-1:0] Q = '0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;

  logic [DW-1:0] ram [RAMSZ];

  int nChecks = 0;
  int nFails  = 0;

  packet_data_reader dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .RdAddress  (RdAddress),
    .RdClockEn  (RdClockEn),
    .Q          (Q),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read RAM: data appears the cycle after the address edge.
  always @(posedge Clock) begin
    if (RdClockEn) Q <= ram[RdAddress];
  end

  // Monitor state, sampled on the falling edge.
  int            cyc = 0;
  logic          monClear = 1'b0;
  logic [DW-1:0] gotData [$];
  logic          gotLast [$];
  int            gotCyc [$];
  logic [AW-1:0] gotAddr [$];
  int            rdCyc [$];
  int            doneCyc [$];
  int            firstValidCyc = -1;
  int            validCycles, busyCycles, stallErr, capErr, idleRdErr, doneBusyErr;
  int            rdTotal, hsTotal;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData;
  logic          prevLast;
  logic          monHs;

  initial begin : monitor
    forever begin
      @(negedge Clock);
      cyc++;
      if (monClear) begin
        gotData.delete(); gotLast.delete(); gotCyc.delete();
        gotAddr.delete(); rdCyc.delete(); doneCyc.delete();
        firstValidCyc = -1;
        validCycles = 0; busyCycles = 0; stallErr = 0; capErr = 0;
        idleRdErr = 0; doneBusyErr = 0; rdTotal = 0; hsTotal = 0;
        prevStall = 1'b0;
      end else begin
        monHs = tx_valid && tx_ready;
        if (tx_valid) begin
          validCycles++;
          if (firstValidCyc < 0) firstValidCyc = cyc;
        end
        if (busy) busyCycles++;
        if (prevStall && (tx_valid !== 1'b1 || tx_data !== prevData || tx_last !== prevLast))
          stallErr++;
        if (RdClockEn) begin
          if (!busy) idleRdErr++;
          // Bytes fetched but not yet delivered may never exceed two.
          if (rdTotal - hsTotal - (monHs ? 1 : 0) >= 2) capErr++;
          gotAddr.push_back(RdAddress);
          rdCyc.push_back(cyc);
          rdTotal++;
        end
        if (monHs) begin
          gotData.push_back(tx_data);
          gotLast.push_back(tx_last);
          gotCyc.push_back(cyc);
          hsTotal++;
        end
        if (done) begin
          doneCyc.push_back(cyc);
          if (busy) doneBusyErr++;
        end
        prevStall = tx_valid && !tx_ready;
        prevData  = tx_data;
        prevLast  = tx_last;
      end
    end
  end

  int   sEdge;
  logic timedOut;
  logic randReady = 1'b0;

  // Drive a one-cycle start request; sEdge marks the sampling edge.
  task automatic applyStimulus(input logic [AW-1:0] a, input int len);
    logic [31:0] lenBits;
    lenBits    = len;
    start      = 1'b1;
    start_addr = a;
    length     = lenBits[AW:0];
    @(posedge Clock);
    sEdge = cyc;
    #1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
  endtask

  task automatic runCycles(input int maxC);
    timedOut = 1'b1;
    for (int i = 0; i < maxC; i++) begin
      @(posedge Clock);
      #1;
      if (randReady) tx_ready = 1'($urandom_range(0, 1));
      if (doneCyc.size() > 0) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic clearMon;
    monClear = 1'b1;
    @(negedge Clock);
    #1;
    monClear = 1'b0;
  endtask

  task automatic fillRandom;
    for (int i = 0; i < RAMSZ; i++) ram[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    Reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; tx_ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    nChecks++;
    if ({busy, done, RdClockEn, tx_valid, tx_last} !== 5'b0) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {busy, done, RdClockEn, tx_valid, tx_last});
    end
    nChecks++;
    if (RdAddress !== '0 || tx_data !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_data: addr %h data %h, expected 0 and 0", RdAddress, tx_data);
    end
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    nChecks++;
    if ({busy, RdClockEn, tx_valid} !== 3'b0) begin
      nFails++;
      $display("[TB] FAIL idle_after_reset: got %b, expected 000", {busy, RdClockEn, tx_valid});
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    tx_ready = 1'b1;
    clearMon;
    applyStimulus(10'h000, 16);
    runCycles(100);
    repeat (4) @(posedge Clock);
    #1;
    nChecks++;
    if (timedOut || gotData.size() != 16) begin
      nFails++;
      $display("[TB] FAIL basic_count: got %0d bytes (timeout %0b), expected 16", gotData.size(), timedOut);
    end
    for (int i = 0; i < gotData.size() && i < 16; i++) begin
      nChecks++;
      if (gotData[i] !== 8'(i) || gotLast[i] !== (i == 15) || gotCyc[i] != sEdge + 3 + i) begin
        nFails++;
        $display("[TB] FAIL basic_byte%0d: got %h last %b cycle %0d, expected %h last %b cycle %0d",
                 i, gotData[i], gotLast[i], gotCyc[i] - sEdge, 8'(i), (i == 15), 3 + i);
      end
    end
    nChecks++;
    if (rdCyc.size() == 0 || rdCyc[0] != sEdge + 1 || firstValidCyc != sEdge + 3) begin
      nFails++;
      $display("[TB] FAIL basic_latency: first read %0d first valid %0d, expected 1 and 3",
               (rdCyc.size() > 0) ? rdCyc[0] - sEdge : -1, firstValidCyc - sEdge);
    end
    nChecks++;
    if (doneCyc.size() != 1 || doneCyc[0] != sEdge + 19) begin
      nFails++;
      $display("[TB] FAIL basic_done: %0d pulses first at %0d, expected 1 at 19",
               doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] - sEdge : -1);
    end
    nChecks++;
    if (stallErr + capErr + idleRdErr + doneBusyErr != 0) begin
      nFails++;
      $display("[TB] FAIL basic_protocol: %0d violations, expected 0", stallErr + capErr + idleRdErr + doneBusyErr);
    end
  endtask

  task automatic test_wrap;
    int bad;
    fillRandom;
    tx_ready = 1'b1;
    clearMon;
    applyStimulus(10'h3FE, 4);
    runCycles(60);
    repeat (3) @(posedge Clock);
    #1;
    nChecks++;
    if (gotAddr.size() != 4 || gotData.size() != 4) begin
      nFails++;
      $display("[TB] FAIL wrap_count: %0d reads %0d bytes, expected 4 and 4", gotAddr.size(), gotData.size());
    end
    bad = 0;
    for (int i = 0; i < gotAddr.size() && i < 4; i++)
      if (gotAddr[i] !== AW'((10'h3FE + i) % RAMSZ)) bad++;
    nChecks++;
    if (bad != 0) begin
      nFails++;
      $display("[TB] FAIL wrap_addr: %0d wrong addresses, expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < gotData.size() && i < 4; i++)
      if (gotData[i] !== ram[(10'h3FE + i) % RAMSZ]) bad++;
    nChecks++;
    if (bad != 0 || doneCyc.size() != 1) begin
      nFails++;
      $display("[TB] FAIL wrap_data: %0d wrong bytes %0d done pulses, expected 0 and 1", bad, doneCyc.size());
    end
  endtask

  task automatic test_backpressure;
    int len, bad, lasts;
    logic [AW-1:0] a;
    fillRandom;
    for (int p = 0; p < 4; p++) begin
      len = (p == 0) ? 8 : int'($urandom_range(1, 20));
      a   = AW'($urandom_range(0, RAMSZ - 1));
      randReady = 1'b1;
      clearMon;
      applyStimulus(a, len);
      runCycles(400);
      randReady = 1'b0;
      tx_ready  = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      bad = 0;
      lasts = 0;
      for (int i = 0; i < gotData.size(); i++) begin
        if (i >= len || gotData[i] !== ram[(a + i) % RAMSZ]) bad++;
        if (gotLast[i]) lasts++;
      end
      nChecks++;
      if (timedOut || gotData.size() != len || bad != 0) begin
        nFails++;
        $display("[TB] FAIL bp_stream%0d: %0d bytes %0d wrong, expected %0d bytes 0 wrong", p, gotData.size(), bad, len);
      end
      nChecks++;
      if (lasts != 1 || gotData.size() == 0 || gotLast[gotData.size() - 1] !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL bp_last%0d: %0d last flags, expected 1 on final byte", p, lasts);
      end
      nChecks++;
      if (stallErr != 0 || capErr != 0 || idleRdErr != 0 || doneCyc.size() != 1) begin
        nFails++;
        $display("[TB] FAIL bp_protocol%0d: stall %0d cap %0d idleRd %0d done %0d, expected 0 0 0 1",
                 p, stallErr, capErr, idleRdErr, doneCyc.size());
      end
    end
  endtask

  task automatic test_zero_and_busy;
    int bad;
    logic [AW-1:0] a;
    tx_ready = 1'b1;
    clearMon;
    applyStimulus(10'h055, 0);
    repeat (4) @(posedge Clock);
    #1;
    nChecks++;
    if (doneCyc.size() != 1 || doneCyc[0] != sEdge + 1) begin
      nFails++;
      $display("[TB] FAIL zero_done: %0d pulses first at %0d, expected 1 at 1",
               doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] - sEdge : -1);
    end
    nChecks++;
    if (gotAddr.size() != 0 || validCycles != 0 || busyCycles != 0) begin
      nFails++;
      $display("[TB] FAIL zero_quiet: reads %0d valid %0d busy %0d, expected 0 0 0",
               gotAddr.size(), validCycles, busyCycles);
    end
    a = 10'h123;
    clearMon;
    applyStimulus(a, 6);
    repeat (2) @(posedge Clock);
    #1;
    start = 1'b1; start_addr = 10'h2AA; length = 11'd3;
    @(posedge Clock);
    #1;
    start = 1'b0; start_addr = '0; length = '0;
    runCycles(60);
    repeat (4) @(posedge Clock);
    #1;
    bad = 0;
    for (int i = 0; i < gotData.size() && i < 6; i++)
      if (gotData[i] !== ram[(a + i) % RAMSZ]) bad++;
    nChecks++;
    if (gotData.size() != 6 || bad != 0 || doneCyc.size() != 1) begin
      nFails++;
      $display("[TB] FAIL busy_ignore: %0d bytes %0d wrong %0d done, expected 6 0 1", gotData.size(), bad, doneCyc.size());
    end
    nChecks++;
    if (gotAddr.size() != 6 || gotAddr[0] !== a) begin
      nFails++;
      $display("[TB] FAIL busy_ignore_addr: %0d reads, expected 6 starting at %h", gotAddr.size(), a);
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    fillRandom;
    tx_ready = 1'b1;
    clearMon;
    applyStimulus(10'h200, 10);
    for (int i = 0; i < 40; i++) begin
      if (gotData.size() >= 3) break;
      @(posedge Clock);
      #1;
    end
    nChecks++;
    if (gotData.size() != 3 || tx_valid !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL abort_setup: %0d bytes valid %b, expected 3 and 1", gotData.size(), tx_valid);
    end
    Reset = 1'b1;
    #1;
    nChecks++;
    if ({busy, done, RdClockEn, tx_valid, tx_last} !== 5'b0 || RdAddress !== '0 || tx_data !== '0) begin
      nFails++;
      $display("[TB] FAIL abort_async: ctrl %b addr %h data %h, expected all 0",
               {busy, done, RdClockEn, tx_valid, tx_last}, RdAddress, tx_data);
    end
    @(posedge Clock);
    #1;
    clearMon;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    repeat (15) @(posedge Clock);
    #1;
    nChecks++;
    if (doneCyc.size() != 0 || validCycles != 0 || gotAddr.size() != 0) begin
      nFails++;
      $display("[TB] FAIL abort_quiet: done %0d valid %0d reads %0d, expected 0 0 0",
               doneCyc.size(), validCycles, gotAddr.size());
    end
    clearMon;
    applyStimulus(10'h020, 5);
    runCycles(60);
    repeat (3) @(posedge Clock);
    #1;
    bad = 0;
    for (int i = 0; i < gotData.size() && i < 5; i++)
      if (gotData[i] !== ram[(10'h020 + i) % RAMSZ]) bad++;
    nChecks++;
    if (gotData.size() != 5 || bad != 0 || doneCyc.size() != 1) begin
      nFails++;
      $display("[TB] FAIL abort_restart: %0d bytes %0d wrong %0d done, expected 5 0 1", gotData.size(), bad, doneCyc.size());
    end
  endtask

  task automatic test_full_length;
    int bad, lasts;
    logic sawDone;
    logic [AW-1:0] a, b;
    fillRandom;
    tx_ready = 1'b1;
    a = 10'h155;
    b = 10'h3FC;
    clearMon;
    applyStimulus(a, 1024);
    sawDone = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge Clock);
      #1;
      if (done) begin
        sawDone = 1'b1;
        break;
      end
    end
    nChecks++;
    if (!sawDone) begin
      nFails++;
      $display("[TB] FAIL full_timeout: done %b, expected 1 within 1100 cycles", sawDone);
    end else begin
      applyStimulus(b, 5);
      bad = 0;
      lasts = 0;
      for (int i = 0; i < gotData.size(); i++) begin
        if (i >= 1024 || gotData[i] !== ram[(a + i) % RAMSZ]) bad++;
        if (gotLast[i]) lasts++;
      end
      nChecks++;
      if (gotData.size() != 1024 || bad != 0) begin
        nFails++;
        $display("[TB] FAIL full_stream: %0d bytes %0d wrong, expected 1024 0", gotData.size(), bad);
      end
      nChecks++;
      if (lasts != 1 || gotData.size() == 0 || gotLast[gotData.size() - 1] !== 1'b1
          || doneCyc.size() != 1 || gotCyc[gotCyc.size() - 1] - gotCyc[0] != 1023) begin
        nFails++;
        $display("[TB] FAIL full_last: %0d last flags %0d done, expected 1 and 1 over 1024 consecutive cycles",
                 lasts, doneCyc.size());
      end
      clearMon;
      runCycles(60);
      repeat (3) @(posedge Clock);
      #1;
      bad = 0;
      for (int i = 0; i < gotData.size() && i < 5; i++)
        if (gotData[i] !== ram[(b + i) % RAMSZ]) bad++;
      nChecks++;
      if (gotData.size() != 5 || bad != 0 || firstValidCyc != sEdge + 3 || doneCyc.size() != 1) begin
        nFails++;
        $display("[TB] FAIL back_to_back: %0d bytes %0d wrong first valid %0d done %0d, expected 5 0 3 1",
                 gotData.size(), bad, firstValidCyc - sEdge, doneCyc.size());
      end
    end
  endtask

  task automatic test_clamp;
    int bad;
    fillRandom;
    tx_ready = 1'b1;
    clearMon;
    applyStimulus(10'h000, 2047);
    runCycles(1200);
    repeat (3) @(posedge Clock);
    #1;
    bad = 0;
    for (int i = 0; i < gotData.size() && i < 1024; i++)
      if (gotData[i] !== ram[i] || gotLast[i] !== (i == 1023)) bad++;
    nChecks++;
    if (timedOut || gotData.size() != 1024 || bad != 0) begin
      nFails++;
      $display("[TB] FAIL clamp_len: %0d bytes %0d wrong, expected 1024 0", gotData.size(), bad);
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; tx_ready = 1'b1;
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_and_busy;
    test_reset_abort;
    test_full_length;
    test_clamp;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
